// File: rtl/id_fwd_stage_pkg.sv
// Shared ISA encodings, ALU operation/result codes and bus widths
// used by the ID stage with EX/MEM forwarding.
package id_fwd_stage_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned ALUOP_W     = 8;
  localparam int unsigned ALUSEL_W    = 3;

  localparam logic        RstEnable  = 1'b1;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  typedef enum logic [ALUOP_W-1:0] {
    EXE_NOP_OP = 8'h00,
    EXE_AND_OP = 8'h24,
    EXE_OR_OP  = 8'h25,
    EXE_XOR_OP = 8'h26,
    EXE_NOR_OP = 8'h27,
    EXE_LW_OP  = 8'hE3
  } aluop_e;

  typedef enum logic [ALUSEL_W-1:0] {
    EXE_RES_NOP        = 3'd0,
    EXE_RES_LOGIC      = 3'd1,
    EXE_RES_LOAD_STORE = 3'd7
  } alusel_e;

endpackage

// File: rtl/id_fwd_stage_opsel.sv
// One operand path: $0 forcing, EX-over-MEM forwarding, regfile fallback,
// immediate for an unread port; also flags a match against the EX destination.
module id_opsel #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned FWD_EN = 1
) (
  input  logic              read_i,
  input  logic [RA_W-1:0]   addr_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              ex_wreg_i,
  input  logic [RA_W-1:0]   ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              mem_wreg_i,
  input  logic [RA_W-1:0]   mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ex_hit_o
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = read_i && (addr_i != '0) && ex_wreg_i  && (ex_wd_i  == addr_i);
  assign mem_match = read_i && (addr_i != '0) && mem_wreg_i && (mem_wd_i == addr_i);

  // Hazard flag is independent of FWD_EN: the load-use stall stays active
  assign ex_hit_o = ex_match;

  always_comb begin
    data_o = imm_i;
    if (read_i) begin
      if (addr_i == '0)                data_o = '0;
      else if (FWD_EN != 0 && ex_match)  data_o = ex_wdata_i;
      else if (FWD_EN != 0 && mem_match) data_o = mem_wdata_i;
      else                               data_o = rdata_i;
    end
  end

endmodule

// File: rtl/id_fwd_stage.sv
// Instruction decode for the logic-immediate/LUI/logic-R/LW subset, operand
// forwarding, load-use stall detection and the ID/EX pipeline register.
module id_fwd_stage
  import id_fwd_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned FWD_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0]      inst_i,
  input  logic [DATA_W-1:0]      reg1_data_i,
  input  logic [DATA_W-1:0]      reg2_data_i,
  output logic                   reg1_read_o,
  output logic                   reg2_read_o,
  output logic [RA_W-1:0]        reg1_addr_o,
  output logic [RA_W-1:0]        reg2_addr_o,
  input  logic                   ex_wreg_i,
  input  logic                   mem_wreg_i,
  input  logic [RA_W-1:0]        ex_wd_i,
  input  logic [RA_W-1:0]        mem_wd_i,
  input  logic [DATA_W-1:0]      ex_wdata_i,
  input  logic [DATA_W-1:0]      mem_wdata_i,
  input  logic                   ex_is_load_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic                   stallreq_o,
  output logic [ALUOP_W-1:0]     ex_aluop_o,
  output logic [ALUSEL_W-1:0]    ex_alusel_o,
  output logic [DATA_W-1:0]      ex_reg1_o,
  output logic [DATA_W-1:0]      ex_reg2_o,
  output logic [RA_W-1:0]        ex_wd_o,
  output logic                   ex_wreg_o,
  output logic [INST_ADDR_W-1:0] ex_pc_o,
  output logic                   ex_inst_valid_o
);

  logic [5:0]      op, func;
  logic [4:0]      shamt;
  logic [RA_W-1:0] rs, rt, rd;

  assign op    = inst_i[31:26];
  assign rs    = RA_W'(inst_i[25:21]);
  assign rt    = RA_W'(inst_i[20:16]);
  assign rd    = RA_W'(inst_i[15:11]);
  assign shamt = inst_i[10:6];
  assign func  = inst_i[5:0];

  aluop_e          aluop_d;
  alusel_e         alusel_d;
  logic [RA_W-1:0] wd_d;
  logic            wreg_d, valid_d, read1, read2;
  logic [DATA_W-1:0] imm;

  always_comb begin
    aluop_d  = EXE_NOP_OP;
    alusel_d = EXE_RES_NOP;
    wd_d     = '0;
    wreg_d   = 1'b0;
    valid_d  = 1'b0;
    read1    = 1'b0;
    read2    = 1'b0;
    imm      = '0;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
        read1    = 1'b1;
        wd_d     = rt;
        wreg_d   = 1'b1;
        valid_d  = 1'b1;
        alusel_d = EXE_RES_LOGIC;
        imm      = DATA_W'(inst_i[15:0]);
        case (op)
          OP_ANDI: aluop_d = EXE_AND_OP;
          OP_XORI: aluop_d = EXE_XOR_OP;
          OP_LUI: begin
            aluop_d = EXE_OR_OP;
            imm     = DATA_W'({inst_i[15:0], 16'h0000});
          end
          default: aluop_d = EXE_OR_OP;
        endcase
      end
      OP_LW: begin
        read1    = 1'b1;
        wd_d     = rt;
        wreg_d   = 1'b1;
        valid_d  = 1'b1;
        aluop_d  = EXE_LW_OP;
        alusel_d = EXE_RES_LOAD_STORE;
        imm      = DATA_W'($signed(inst_i[15:0]));
      end
      OP_SPECIAL: begin
        if (shamt == 5'd0 && (func == FN_AND || func == FN_OR ||
                              func == FN_XOR || func == FN_NOR)) begin
          read1    = 1'b1;
          read2    = 1'b1;
          wd_d     = rd;
          wreg_d   = 1'b1;
          valid_d  = 1'b1;
          alusel_d = EXE_RES_LOGIC;
          case (func)
            FN_AND:  aluop_d = EXE_AND_OP;
            FN_OR:   aluop_d = EXE_OR_OP;
            FN_XOR:  aluop_d = EXE_XOR_OP;
            default: aluop_d = EXE_NOR_OP;
          endcase
        end
      end
      default: ;
    endcase
    if (inst_i == '0) valid_d = 1'b1;
  end

  logic in_rst;
  assign in_rst      = (rst == RstEnable);
  assign reg1_read_o = read1 && !in_rst;
  assign reg2_read_o = read2 && !in_rst;
  assign reg1_addr_o = in_rst ? '0 : rs;
  assign reg2_addr_o = in_rst ? '0 : rt;

  logic [DATA_W-1:0] op1, op2;
  logic              hit1, hit2;

  id_opsel #(.DATA_W(DATA_W), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_opsel1 (
    .read_i(reg1_read_o), .addr_i(reg1_addr_o), .rdata_i(reg1_data_i), .imm_i(imm),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .data_o(op1), .ex_hit_o(hit1)
  );

  id_opsel #(.DATA_W(DATA_W), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_opsel2 (
    .read_i(reg2_read_o), .addr_i(reg2_addr_o), .rdata_i(reg2_data_i), .imm_i(imm),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .data_o(op2), .ex_hit_o(hit2)
  );

  assign stallreq_o = ex_is_load_i && (hit1 || hit2);

  aluop_e                 aluop_q;
  alusel_e                alusel_q;
  logic [DATA_W-1:0]      reg1_q, reg2_q;
  logic [RA_W-1:0]        wd_q;
  logic                   wreg_q, valid_q;
  logic [INST_ADDR_W-1:0] pc_q;

  // rst and flush beat stall; a load bubble is inserted only when not stalled
  always_ff @(posedge clk) begin
    if (in_rst || flush_i || (!stall_i && stallreq_o)) begin
      aluop_q  <= EXE_NOP_OP;
      alusel_q <= EXE_RES_NOP;
      reg1_q   <= DATA_W'(ZeroWord);
      reg2_q   <= DATA_W'(ZeroWord);
      wd_q     <= RA_W'(NOPRegAddr);
      wreg_q   <= 1'b0;
      valid_q  <= 1'b0;
      pc_q     <= ZeroWord;
    end else if (!stall_i) begin
      aluop_q  <= aluop_d;
      alusel_q <= alusel_d;
      reg1_q   <= op1;
      reg2_q   <= op2;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      valid_q  <= valid_d;
      pc_q     <= pc_i;
    end
  end

  assign ex_aluop_o      = aluop_q;
  assign ex_alusel_o     = alusel_q;
  assign ex_reg1_o       = reg1_q;
  assign ex_reg2_o       = reg2_q;
  assign ex_wd_o         = wd_q;
  assign ex_wreg_o       = wreg_q;
  assign ex_pc_o         = pc_q;
  assign ex_inst_valid_o = valid_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage: decode/forwarding vector table plus
// reset, stall, flush and load-use sequences.
module tb_id_fwd_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic        ex_wreg_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        ex_is_load_i, stall_i, flush_i, stallreq_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_reg1_o, ex_reg2_o, ex_pc_o;
  logic [4:0]  ex_wd_o;
  logic        ex_wreg_o, ex_inst_valid_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_fwd_stage #(.DATA_W(32), .RA_W(5), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .ex_wreg_i(ex_wreg_i), .mem_wreg_i(mem_wreg_i),
    .ex_wd_i(ex_wd_i), .mem_wd_i(mem_wd_i),
    .ex_wdata_i(ex_wdata_i), .mem_wdata_i(mem_wdata_i),
    .ex_is_load_i(ex_is_load_i), .stall_i(stall_i), .flush_i(flush_i),
    .stallreq_o(stallreq_o),
    .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
    .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
    .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
    .ex_pc_o(ex_pc_o), .ex_inst_valid_o(ex_inst_valid_o)
  );

  typedef struct packed {
    logic [31:0] inst, r1d, r2d;
    logic        exw;  logic [4:0] exwd; logic [31:0] exdat;
    logic        mw;   logic [4:0] mwd;  logic [31:0] mdat;
    logic        ld;
    logic        e_stall, e_rd1, e_rd2;
    logic [7:0]  e_op;   logic [2:0] e_sel;
    logic [31:0] e_r1, e_r2;
    logic [4:0]  e_wd;   logic e_wreg, e_valid;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd,
                        input logic wreg, input logic valid, input logic [31:0] pc);
    chk({tag, " aluop"},  32'(ex_aluop_o),      32'(op));
    chk({tag, " alusel"}, 32'(ex_alusel_o),     32'(sel));
    chk({tag, " reg1"},   ex_reg1_o,            r1);
    chk({tag, " reg2"},   ex_reg2_o,            r2);
    chk({tag, " wd"},     32'(ex_wd_o),         32'(wd));
    chk({tag, " wreg"},   32'(ex_wreg_o),       32'(wreg));
    chk({tag, " valid"},  32'(ex_inst_valid_o), 32'(valid));
    chk({tag, " pc"},     ex_pc_o,              pc);
  endtask

  task automatic set_idle();
    pc_i = '0; inst_i = '0; reg1_data_i = '0; reg2_data_i = '0;
    ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0;
    mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
    ex_is_load_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    inst_i = v.inst; reg1_data_i = v.r1d; reg2_data_i = v.r2d;
    ex_wreg_i = v.exw; ex_wd_i = v.exwd; ex_wdata_i = v.exdat;
    mem_wreg_i = v.mw; mem_wd_i = v.mwd; mem_wdata_i = v.mdat;
    ex_is_load_i = v.ld;
  endtask

  task automatic load_hazard_and();
    inst_i = 32'h00862824;             // AND $5,$4,$6
    ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_wdata_i = 32'h0000BAD0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins, exp_pc;
    logic [31:0] stall_insts [3];

    vecs[0]  = '{32'h34011100, 32'h00007777, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h25, 3'd1, 32'h0, 32'h00001100, 5'd1, 1'b1, 1'b1};
    vecs[1]  = '{32'h30628001, 32'h12345678, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h24, 3'd1, 32'h12345678, 32'h00008001, 5'd2, 1'b1, 1'b1};
    vecs[2]  = '{32'h3949FFFF, 32'h0, 32'h0, 1'b1, 5'd11, 32'hDEADBEEF, 1'b1, 5'd10, 32'hCAFEBABE, 1'b0, 1'b0, 1'b1, 1'b0, 8'h26, 3'd1, 32'hCAFEBABE, 32'h0000FFFF, 5'd9, 1'b1, 1'b1};
    vecs[3]  = '{32'h3C05ABCD, 32'h5A5A5A5A, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h25, 3'd1, 32'h0, 32'hABCD0000, 5'd5, 1'b1, 1'b1};
    vecs[4]  = '{32'h00221825, 32'h11111111, 32'h00005555, 1'b1, 5'd1, 32'hAAAA0000, 1'b1, 5'd1, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1, 8'h25, 3'd1, 32'hAAAA0000, 32'h00005555, 5'd3, 1'b1, 1'b1};
    vecs[5]  = '{32'h00C74027, 32'h00000066, 32'h00000099, 1'b0, 5'd6, 32'h0000DEAD, 1'b1, 5'd7, 32'h00000077, 1'b0, 1'b0, 1'b1, 1'b1, 8'h27, 3'd1, 32'h00000066, 32'h00000077, 5'd8, 1'b1, 1'b1};
    vecs[6]  = '{32'h00422026, 32'h00000001, 32'h00000002, 1'b1, 5'd2, 32'h0F0F0F0F, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h26, 3'd1, 32'h0F0F0F0F, 32'h0F0F0F0F, 5'd4, 1'b1, 1'b1};
    vecs[7]  = '{32'h00221865, 32'h11111111, 32'h22222222, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    vecs[8]  = '{32'h8FA4FFFC, 32'h00001000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE3, 3'd7, 32'h00001000, 32'hFFFFFFFC, 5'd4, 1'b1, 1'b1};
    vecs[9]  = '{32'h34070000, 32'h00003333, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h25, 3'd1, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1};
    vecs[10] = '{32'h34430005, 32'h00000022, 32'h0, 1'b1, 5'd3, 32'h00000999, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h25, 3'd1, 32'h00000022, 32'h00000005, 5'd3, 1'b1, 1'b1};
    vecs[11] = '{32'hFC000000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    vecs[12] = '{32'h00000000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
    vecs[13] = '{32'h00862824, 32'h00004444, 32'h00006666, 1'b1, 5'd4, 32'h0000BAD0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    vecs[14] = '{32'h00862824, 32'h00004444, 32'h00006666, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h0000F0F0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h24, 3'd1, 32'h0000F0F0, 32'h00006666, 5'd5, 1'b1, 1'b1};

    // Reset with a load-use hazard presented: everything must stay quiet
    set_idle();
    rst = 1'b1;
    load_hazard_and();
    pc_i = 32'h00000ABC;
    @(negedge clk); #1;
    chk("rst stallreq", 32'(stallreq_o), 32'h0);
    chk("rst read1", 32'(reg1_read_o), 32'h0);
    chk("rst read2", 32'(reg2_read_o), 32'h0);
    chk("rst addr1", 32'(reg1_addr_o), 32'h0);
    chk("rst addr2", 32'(reg2_addr_o), 32'h0);
    @(posedge clk); #1;
    chk_ex("rst", 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    set_idle();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      pc_i = 32'h00001000 + 32'(i) * 32'd4;
      ins = vecs[i].inst;
      #1;
      chk($sformatf("v%0d stallreq", i), 32'(stallreq_o), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d read1", i), 32'(reg1_read_o), 32'(vecs[i].e_rd1));
      chk($sformatf("v%0d read2", i), 32'(reg2_read_o), 32'(vecs[i].e_rd2));
      chk($sformatf("v%0d addr1", i), 32'(reg1_addr_o), 32'(ins[25:21]));
      chk($sformatf("v%0d addr2", i), 32'(reg2_addr_o), 32'(ins[20:16]));
      exp_pc = vecs[i].e_stall ? 32'h0 : pc_i;
      @(posedge clk); #1;
      chk_ex($sformatf("v%0d", i), vecs[i].e_op, vecs[i].e_sel, vecs[i].e_r1, vecs[i].e_r2,
             vecs[i].e_wd, vecs[i].e_wreg, vecs[i].e_valid, exp_pc);
    end

    // Stall for three cycles with changing input; the register must hold
    @(negedge clk);
    set_idle();
    inst_i = 32'h34011100; pc_i = 32'h00002000; reg1_data_i = 32'h00007777;
    @(posedge clk); #1;
    chk_ex("prestall", 8'h25, 3'd1, 32'h0, 32'h00001100, 5'd1, 1'b1, 1'b1, 32'h00002000);
    stall_insts[0] = 32'h00862824;
    stall_insts[1] = 32'h3C05ABCD;
    stall_insts[2] = 32'h00221825;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_idle();
      stall_i = 1'b1;
      if (k == 0) load_hazard_and();
      inst_i = stall_insts[k];
      pc_i = 32'h00003000 + 32'(k) * 32'd4;
      reg1_data_i = 32'h13579BDF; reg2_data_i = 32'h2468ACE0;
      if (k == 0) begin
        #1;
        chk("stall0 stallreq", 32'(stallreq_o), 32'h1);
      end
      @(posedge clk); #1;
      chk_ex($sformatf("stall%0d", k), 8'h25, 3'd1, 32'h0, 32'h00001100, 5'd1, 1'b1, 1'b1, 32'h00002000);
    end

    // Flush together with stall loads a NOP
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    chk_ex("flush", 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);

    // Reset mid-stall overrides the hold
    @(negedge clk);
    set_idle();
    inst_i = 32'h3949FFFF; pc_i = 32'h00004000; reg1_data_i = 32'h0000A5A5;
    @(posedge clk); #1;
    chk_ex("prerst", 8'h26, 3'd1, 32'h0000A5A5, 32'h0000FFFF, 5'd9, 1'b1, 1'b1, 32'h00004000);
    @(negedge clk);
    stall_i = 1'b1;
    rst = 1'b1;
    load_hazard_and();
    #1;
    chk("rststall stallreq", 32'(stallreq_o), 32'h0);
    @(posedge clk); #1;
    chk_ex("rststall", 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
